// File: rtl/seg_fade_pkg.sv
// seg_fade_pkg: mode/direction encodings and default parameters shared by the fade chaser.
package seg_fade_pkg;

  typedef enum logic [1:0] {
    MODE_FWD    = 2'b00,
    MODE_REV    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int DEF_NCH          = 7;
  localparam int DEF_BRIGHT_W     = 4;
  localparam int DEF_PRESC_W      = 22;
  localparam int DEF_SEQ_LEN      = 8;
  localparam int DEF_COMMON_ANODE = 1;

endpackage

// File: rtl/seg_fade_prescaler.sv
// seg_fade_prescaler: free-running divider producing a tick every period+1 enabled cycles.
module seg_fade_prescaler
  import seg_fade_pkg::*;
#(
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [PRESC_W-1:0] period,
  output logic               tick
);

  logic [PRESC_W-1:0] count;

  // A count already past a freshly shortened period ends the interval instead of wrapping the full range.
  assign tick = enable && (count >= period);

  // Count up while enabled and restart from zero after each tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else if (enable) begin
      count <= count + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/seg_fade_chaser.sv
// seg_fade_chaser: steps through a channel sequence, lights each visited channel fully and
// lets all channels decay, driving the LEDs through a per-channel PWM comparator.
module seg_fade_chaser
  import seg_fade_pkg::*;
#(
  parameter int  NCH          = DEF_NCH,
  parameter int  BRIGHT_W     = DEF_BRIGHT_W,
  parameter int  PRESC_W      = DEF_PRESC_W,
  parameter int  SEQ_LEN      = DEF_SEQ_LEN,
  parameter int  COMMON_ANODE = DEF_COMMON_ANODE,
  localparam int AW           = $clog2(SEQ_LEN),
  localparam int CW           = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [PRESC_W-1:0] step_period,
  input  logic [PRESC_W-1:0] fade_period,
  input  logic [1:0]         fade_shift,
  input  logic [1:0]         mode,
  input  logic               seq_we,
  input  logic [AW-1:0]      seq_addr,
  input  logic [CW-1:0]      seq_wdata,
  output logic [NCH-1:0]     led_out,
  output logic [AW-1:0]      pos,
  output logic               step_pulse
);

  localparam logic [AW-1:0]       LAST_POS = AW'(SEQ_LEN - 1);
  localparam logic [AW-1:0]       ONE_POS  = AW'(1);
  localparam logic [BRIGHT_W-1:0] FULL     = '1;
  localparam logic                LED_OFF  = (COMMON_ANODE != 0);

  logic                step_tick;
  logic                fade_tick;
  mode_e               mode_sel;
  dir_e                dir_q;
  dir_e                dir_nxt;
  logic [AW-1:0]       pos_nxt;
  logic [CW-1:0]       seq_tab [SEQ_LEN];
  logic [CW-1:0]       load_ch;
  logic                load_valid;
  logic [BRIGHT_W-1:0] bright [NCH];
  logic [BRIGHT_W-1:0] pwm_cnt;

  assign mode_sel = mode_e'(mode);

  seg_fade_prescaler #(.PRESC_W(PRESC_W)) u_step_presc (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .period (step_period),
    .tick   (step_tick)
  );

  seg_fade_prescaler #(.PRESC_W(PRESC_W)) u_fade_presc (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .period (fade_period),
    .tick   (fade_tick)
  );

  // Next position and bounce direction for the coming step, chosen by the current mode.
  always_comb begin
    pos_nxt = pos;
    dir_nxt = dir_q;
    case (mode_sel)
      MODE_FWD: pos_nxt = (pos == LAST_POS) ? '0 : pos + ONE_POS;
      MODE_REV: pos_nxt = (pos == '0) ? LAST_POS : pos - ONE_POS;
      MODE_BOUNCE: begin
        if (dir_q == DIR_UP) begin
          if (pos == LAST_POS) begin
            dir_nxt = DIR_DOWN;
            pos_nxt = LAST_POS - ONE_POS;
          end else begin
            pos_nxt = pos + ONE_POS;
          end
        end else begin
          if (pos == '0) begin
            dir_nxt = DIR_UP;
            pos_nxt = ONE_POS;
          end else begin
            pos_nxt = pos - ONE_POS;
          end
        end
      end
      default: pos_nxt = pos;
    endcase
  end

  // Table entries naming a channel beyond NCH are placeholders that light nothing.
  assign load_ch    = seq_tab[pos_nxt];
  assign load_valid = step_tick && (int'(load_ch) < NCH);

  // Position, direction and the step strobe advance only on step ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos        <= '0;
      dir_q      <= DIR_UP;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= step_tick;
      if (step_tick) begin
        pos   <= pos_nxt;
        dir_q <= dir_nxt;
      end
    end
  end

  // Sequence table: identity-like default mapping, writable at any time including while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SEQ_LEN; i++) begin
        seq_tab[i] <= CW'(i % NCH);
      end
    end else if (seq_we && (int'(seq_addr) < SEQ_LEN)) begin
      seq_tab[seq_addr] <= seq_wdata;
    end
  end

  // Freshly stepped-onto channel goes to full, which wins over a coincident decay.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        bright[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (load_valid && (int'(load_ch) == i)) begin
          bright[i] <= FULL;
        end else if (fade_tick) begin
          bright[i] <= bright[i] >> fade_shift;
        end
      end
    end
  end

  // PWM ramp keeps running while disabled so frozen brightness stays visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
    end
  end

  // Registered LED drive, inverted for common-anode wiring so reset means dark.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_out <= {NCH{LED_OFF}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        led_out[i] <= (bright[i] > pwm_cnt) ^ LED_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg_fade_chaser.sv
// tb_seg_fade_chaser: two chaser instances (sequence depths 8 and 6) checked every cycle
// against a behavioural model, plus hand-computed scenario expectations.
module tb_seg_fade_chaser;

  localparam int NCH   = 7;
  localparam int BW    = 4;
  localparam int PW    = 22;
  localparam int LEN_A = 8;
  localparam int LEN_B = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [PW-1:0] step_period;
  logic [PW-1:0] fade_period;
  logic [1:0]    fade_shift;
  logic [1:0]    mode;
  logic          seq_we;
  logic [2:0]    seq_addr;
  logic [2:0]    seq_wdata;

  logic [1:0][NCH-1:0] led_o;
  logic [1:0][2:0]     pos_o;
  logic [1:0]          pulse_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_fade_chaser #(.NCH(NCH), .BRIGHT_W(BW), .PRESC_W(PW), .SEQ_LEN(LEN_A), .COMMON_ANODE(1)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .step_period(step_period), .fade_period(fade_period),
    .fade_shift(fade_shift), .mode(mode), .seq_we(seq_we), .seq_addr(seq_addr), .seq_wdata(seq_wdata),
    .led_out(led_o[0]), .pos(pos_o[0]), .step_pulse(pulse_o[0])
  );

  seg_fade_chaser #(.NCH(NCH), .BRIGHT_W(BW), .PRESC_W(PW), .SEQ_LEN(LEN_B), .COMMON_ANODE(1)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .step_period(step_period), .fade_period(fade_period),
    .fade_shift(fade_shift), .mode(mode), .seq_we(seq_we), .seq_addr(seq_addr), .seq_wdata(seq_wdata),
    .led_out(led_o[1]), .pos(pos_o[1]), .step_pulse(pulse_o[1])
  );

  // Behavioural model state
  int           seq_len [2] = '{LEN_A, LEN_B};
  bit           m_ok = 1'b0;
  int           m_scnt, m_fcnt, m_pwm;
  bit           m_pulse;
  int           m_pos [2];
  bit           m_up [2];
  int           m_bright [2][NCH];
  int           m_tab [2][8];
  logic [NCH-1:0] m_led [2];

  // Scenario expectation tables
  int bounce_a [16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
  int bounce_b [16] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 4};
  int fade_seq [4]  = '{7, 3, 1, 0};
  int want [NCH];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit en, input logic [1:0] md, input int sp, input int fp,
                               input logic [1:0] fs);
    enable      = en;
    mode        = md;
    step_period = PW'(sp);
    fade_period = PW'(fp);
    fade_shift  = fs;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Two reset edges; outputs are checked right after the first one, whatever was running before.
  task automatic reset_dut();
    reset = 1'b1;
    next_cycle();
    for (int m = 0; m < 2; m++) begin
      checkOutput($sformatf("reset led_out[%0d]", m), led_o[m], 32'h7F);
      checkOutput($sformatf("reset pos[%0d]", m), pos_o[m], 0);
      checkOutput($sformatf("reset step_pulse[%0d]", m), pulse_o[m], 0);
    end
    next_cycle();
    reset = 1'b0;
  endtask

  // Count lit cycles (active-low drive) of every channel over one full PWM period.
  task automatic check_duty(input int inst, input int exp_duty [NCH], input string tag);
    int on_cnt [NCH];
    for (int c = 0; c < NCH; c++) on_cnt[c] = 0;
    for (int k = 0; k < 16; k++) begin
      next_cycle();
      for (int c = 0; c < NCH; c++) begin
        if (led_o[inst][c] == 1'b0) on_cnt[c]++;
      end
    end
    for (int c = 0; c < NCH; c++) begin
      checkOutput($sformatf("%s duty[%0d] ch%0d", tag, inst, c), on_cnt[c], exp_duty[c]);
    end
  endtask

  // Model: derive next outputs from the rules using plain integer arithmetic.
  always @(posedge clk) begin
    bit st;
    bit ft;
    int ch;
    if (reset) begin
      m_ok    = 1'b1;
      m_scnt  = 0;
      m_fcnt  = 0;
      m_pwm   = 0;
      m_pulse = 1'b0;
      for (int m = 0; m < 2; m++) begin
        m_pos[m] = 0;
        m_up[m]  = 1'b1;
        m_led[m] = '1;
        for (int i = 0; i < NCH; i++) m_bright[m][i] = 0;
        for (int i = 0; i < 8; i++) m_tab[m][i] = i % NCH;
      end
    end else if (m_ok) begin
      st = enable && (m_scnt == int'(step_period));
      ft = enable && (m_fcnt == int'(fade_period));
      if (enable) begin
        m_scnt = st ? 0 : m_scnt + 1;
        m_fcnt = ft ? 0 : m_fcnt + 1;
      end
      m_pulse = st;
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < NCH; i++) m_led[m][i] = !(m_bright[m][i] > m_pwm);
        if (st) begin
          case (mode)
            2'd0: m_pos[m] = (m_pos[m] + 1) % seq_len[m];
            2'd1: m_pos[m] = (m_pos[m] + seq_len[m] - 1) % seq_len[m];
            2'd2: begin
              if (m_up[m]) begin
                if (m_pos[m] == seq_len[m] - 1) begin m_up[m] = 1'b0; m_pos[m] = seq_len[m] - 2; end
                else m_pos[m] = m_pos[m] + 1;
              end else begin
                if (m_pos[m] == 0) begin m_up[m] = 1'b1; m_pos[m] = 1; end
                else m_pos[m] = m_pos[m] - 1;
              end
            end
            default: ;
          endcase
        end
        if (ft) for (int i = 0; i < NCH; i++) m_bright[m][i] = m_bright[m][i] >> fade_shift;
        ch = m_tab[m][m_pos[m]];
        if (st && ch < NCH) m_bright[m][ch] = 15;
        if (seq_we && int'(seq_addr) < seq_len[m]) m_tab[m][seq_addr] = int'(seq_wdata);
      end
      m_pwm = (m_pwm + 1) % 16;
    end
  end

  // Compare every DUT output against the model on every cycle once the model is initialised.
  always @(negedge clk) begin
    if (m_ok) begin
      for (int m = 0; m < 2; m++) begin
        checkOutput($sformatf("model led_out[%0d]", m), led_o[m], m_led[m]);
        checkOutput($sformatf("model pos[%0d]", m), pos_o[m], m_pos[m]);
        checkOutput($sformatf("model step_pulse[%0d]", m), pulse_o[m], m_pulse);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    seq_we    = 1'b0;
    seq_addr  = '0;
    seq_wdata = '0;
    applyStimulus(1'b0, 2'd0, 0, 0, 2'd0);

    // Forward stepping every 4 cycles, all visited channels end at full brightness.
    $display("[TB] forward stepping");
    applyStimulus(1'b0, 2'd0, 3, 1000, 2'd0);
    reset_dut();
    enable = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      next_cycle();
      checkOutput("forward step_pulse cadence", pulse_o[0], (n % 4 == 0));
      if (n % 4 == 0) begin
        checkOutput("forward pos len8", pos_o[0], (n / 4) % LEN_A);
        checkOutput("forward pos len6", pos_o[1], (n / 4) % LEN_B);
      end
    end
    enable = 1'b0;
    want = '{15, 15, 15, 15, 15, 15, 15};
    check_duty(0, want, "forward full");

    // Bounce turns around at both ends.
    $display("[TB] bounce");
    applyStimulus(1'b0, 2'd2, 0, 1000, 2'd0);
    reset_dut();
    enable = 1'b1;
    for (int n = 0; n < 16; n++) begin
      next_cycle();
      checkOutput("bounce pos len8", pos_o[0], bounce_a[n]);
      checkOutput("bounce pos len6", pos_o[1], bounce_b[n]);
    end
    enable = 1'b0;

    // Coincident step and fade: new channel full, previous one halved.
    $display("[TB] coincident ticks");
    applyStimulus(1'b0, 2'd0, 1, 1, 2'd1);
    reset_dut();
    enable = 1'b1;
    for (int n = 0; n < 4; n++) next_cycle();
    enable = 1'b0;
    want = '{0, 7, 15, 0, 0, 0, 0};
    check_duty(0, want, "coincident");
    check_duty(1, want, "coincident");

    // Decay by one bit per enabled cycle while the step prescaler is held off.
    $display("[TB] fade staircase");
    applyStimulus(1'b0, 2'd0, 0, 0, 2'd1);
    reset_dut();
    enable = 1'b1;
    next_cycle();
    enable = 1'b0;
    step_period = PW'(200);
    want = '{0, 15, 0, 0, 0, 0, 0};
    check_duty(0, want, "fade load");
    for (int s = 0; s < 4; s++) begin
      enable = 1'b1;
      next_cycle();
      enable = 1'b0;
      want = '{0, fade_seq[s], 0, 0, 0, 0, 0};
      check_duty(0, want, $sformatf("fade step%0d", s));
    end

    // Table writes: one swallowed by reset, one remapping entry 2, one beyond the short table.
    $display("[TB] sequence writes");
    applyStimulus(1'b0, 2'd0, 0, 1000, 2'd0);
    seq_we    = 1'b1;
    seq_addr  = 3'd1;
    seq_wdata = 3'd5;
    reset_dut();
    seq_addr  = 3'd2;
    seq_wdata = 3'd6;
    next_cycle();
    seq_addr  = 3'd7;
    seq_wdata = 3'd3;
    next_cycle();
    seq_we = 1'b0;
    enable = 1'b1;
    next_cycle();
    next_cycle();
    enable = 1'b0;
    want = '{0, 15, 0, 0, 0, 0, 15};
    check_duty(0, want, "remap");
    check_duty(1, want, "remap");

    // Randomised segments, each starting with a mid-run reset.
    $display("[TB] random segments");
    for (int seg = 0; seg < 6; seg++) begin
      applyStimulus(1'b1, 2'($urandom_range(3, 0)), $urandom_range(5, 0), $urandom_range(7, 0),
                    2'($urandom_range(3, 0)));
      seq_we = 1'b1;
      reset_dut();
      for (int n = 0; n < 500; n++) begin
        enable = ($urandom_range(7, 0) != 0);
        if ($urandom_range(39, 0) == 0) mode = 2'($urandom_range(3, 0));
        if ($urandom_range(63, 0) == 0) fade_shift = 2'($urandom_range(3, 0));
        seq_we    = ($urandom_range(7, 0) == 0);
        seq_addr  = 3'($urandom_range(7, 0));
        seq_wdata = 3'($urandom_range(7, 0));
        next_cycle();
      end
      seq_we = 1'b0;
    end

    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
